// File: rtl/uart_pkg.sv
// Shared types and constants for the UART console-out bridge.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } uart_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; full/empty are decoded straight from the pointers.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Same index with opposite wrap bits means the writer has lapped the reader.
  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/uart_tx_bridge.sv
// Buffers the core's console-out bytes and serialises them as 8N1 UART on a registered TX pin.
module uart_tx_bridge
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_uart_out_valid,
  input  logic [7:0]  io_uart_out_ch,
  output logic        uart_tx,
  output logic        tx_busy,
  output logic        fifo_full,
  output logic        fifo_empty,
  output logic [15:0] drop_cnt
);

  localparam int                CNT_W    = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0]  BAUD_MAX = CNT_W'(CLK_DIV - 1);
  localparam logic [2:0]        LAST_BIT = 3'(UART_DATA_BITS - 1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  uart_tx_state_t   state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic [7:0]       fifo_dout;
  logic             push;
  logic             pop;
  logic             bit_end;

  assign bit_end = (baud_cnt == '0);
  assign push    = io_uart_out_valid && !fifo_full;
  // A new frame starts either from idle or on the final stop-bit cycle, giving gapless back-to-back frames.
  assign pop     = !fifo_empty &&
                   ((state == TX_IDLE) || ((state == TX_STOP) && bit_end));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (io_uart_out_ch),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= TX_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      case (state)
        TX_IDLE: begin
          if (pop) begin
            state    <= TX_START;
            baud_cnt <= BAUD_MAX;
          end
        end
        TX_START: begin
          if (bit_end) begin
            state    <= TX_DATA;
            baud_cnt <= BAUD_MAX;
            bit_idx  <= '0;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            baud_cnt <= BAUD_MAX;
            if (bit_idx == LAST_BIT) state <= TX_STOP;
            else                     bit_idx <= bit_idx + 1'b1;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        TX_STOP: begin
          if (bit_end) begin
            if (pop) begin
              state    <= TX_START;
              baud_cnt <= BAUD_MAX;
            end else begin
              state <= TX_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (pop)                              shift_reg <= fifo_dout;
    else if ((state == TX_DATA) && bit_end) shift_reg <= shift_reg >> 1;
  end

  // Line and busy flag are registered from the current state, so they trail it by one clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      uart_tx <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      case (state)
        TX_START: uart_tx <= 1'b0;
        TX_DATA:  uart_tx <= shift_reg[0];
        default:  uart_tx <= 1'b1;
      endcase
      tx_busy <= (state != TX_IDLE);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else if (io_uart_out_valid && fifo_full) begin
      drop_cnt <= sat_inc16(drop_cnt);
    end
  end

endmodule

// File: tb/tb_uart_tx_bridge.sv
// Randomised scoreboard bench for uart_tx_bridge: queue-based model plus a serial-line decoder.
module tb_uart_tx_bridge;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;
  localparam int PER     = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_uart_out_valid = 1'b0;
  logic [7:0]  io_uart_out_ch = 8'h00;
  logic        uart_tx, tx_busy, fifo_full, fifo_empty;
  logic [15:0] drop_cnt;

  logic        reset2 = 1'b0;
  logic        valid2 = 1'b0;
  logic        tx2, busy2, full2, empty2;
  logic [15:0] drop2;

  int total = 0;
  int bad   = 0;

  always #(PER/2) clock = ~clock;

  uart_tx_bridge #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .io_uart_out_valid(io_uart_out_valid), .io_uart_out_ch(io_uart_out_ch),
    .uart_tx(uart_tx), .tx_busy(tx_busy), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .drop_cnt(drop_cnt)
  );

  uart_tx_bridge #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(2)) dut2 (
    .clock(clock), .reset(reset2),
    .io_uart_out_valid(valid2), .io_uart_out_ch(8'h5A),
    .uart_tx(tx2), .tx_busy(busy2), .fifo_full(full2),
    .fifo_empty(empty2), .drop_cnt(drop2)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: byte queue, frame timer (clocks left in current frame), drop count.
  logic [7:0] m_fifo[$];
  logic [7:0] sb[$];
  int         m_tmr  = 0;
  bit         m_busy = 0;
  int         m_drop = 0;
  int         m_occ;
  bit         m_pop;
  bit         m_acc;

  always @(posedge clock) begin
    if (!reset) begin
      m_fifo.delete();
      sb.delete();
      m_tmr  = 0;
      m_busy = 0;
      m_drop = 0;
    end else begin
      m_occ  = m_fifo.size();
      m_pop  = (m_occ > 0) && (m_tmr <= 1);
      m_busy = (m_tmr > 0);
      m_acc  = io_uart_out_valid && (m_occ < DEPTH);
      if (io_uart_out_valid && !m_acc && m_drop < 65535) m_drop++;
      if (m_pop) begin
        sb.push_back(m_fifo.pop_front());
        m_tmr = 10 * CLK_DIV;
      end else if (m_tmr > 0) begin
        m_tmr--;
      end
      if (m_acc) m_fifo.push_back(io_uart_out_ch);
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      chk("flag_full",  fifo_full,  m_fifo.size() == DEPTH);
      chk("flag_empty", fifo_empty, m_fifo.size() == 0);
      chk("drop_cnt",   drop_cnt,   m_drop);
      chk("tx_busy",    tx_busy,    m_busy);
    end
  end

  // Line decoder: samples each bit mid-cell and checks bytes against the scoreboard.
  bit         rx_active = 0;
  int         rx_t;
  logic [7:0] rx_byte;
  realtime    frame_t[$];

  always @(negedge clock) begin
    if (!reset) begin
      rx_active = 0;
    end else if (!rx_active) begin
      if (uart_tx === 1'b0) begin
        rx_active = 1;
        rx_t = 0;
        frame_t.push_back($realtime);
      end
    end else begin
      rx_t++;
      if (rx_t == 2) begin
        chk("rx_start", uart_tx, 1'b0);
      end else if (rx_t >= 6 && rx_t <= 34 && ((rx_t - 6) % 4) == 0) begin
        rx_byte[(rx_t - 6) / 4] = uart_tx;
      end else if (rx_t == 38) begin
        chk("rx_stop", uart_tx, 1'b1);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_unexpected: got frame %0h expected none", rx_byte);
        end else begin
          chk("rx_byte", rx_byte, sb.pop_front());
        end
        rx_active = 0;
      end
    end
  end

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while (!(m_fifo.size() == 0 && m_tmr == 0 && sb.size() == 0 && !rx_active) && n < max_cyc) begin
      @(negedge clock);
      n++;
    end
    chk("idle_timeout", n >= max_cyc, 0);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clock);
    io_uart_out_valid = 1'b1;
    io_uart_out_ch    = b;
  endtask

  task automatic stop_send();
    @(negedge clock);
    io_uart_out_valid = 1'b0;
  endtask

  initial begin
    fork
      begin : main_seq
        bit saw_low;
        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_tx",    uart_tx,    1'b1);
        chk("rst_busy",  tx_busy,    1'b0);
        chk("rst_empty", fifo_empty, 1'b1);
        chk("rst_full",  fifo_full,  1'b0);
        chk("rst_drop",  drop_cnt,   16'h0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Single byte latency and busy window
        send(8'h55);
        stop_send();
        chk("t2_n0", uart_tx, 1'b1);
        @(negedge clock); chk("t2_n1", uart_tx, 1'b1);
        @(negedge clock); chk("t2_n2", uart_tx, 1'b0);
        repeat (39) @(negedge clock);
        chk("t2_busy_n41", tx_busy, 1'b1);
        @(negedge clock);
        chk("t2_busy_n42", tx_busy, 1'b0);
        wait_idle(100);

        // Back-to-back frames
        frame_t.delete();
        send(8'hA5);
        send(8'h3C);
        stop_send();
        wait_idle(200);
        chk("t3_frames", frame_t.size(), 2);
        if (frame_t.size() == 2)
          chk("t3_gap", int'((frame_t[1] - frame_t[0]) / PER), 10 * CLK_DIV);

        // Overflow from idle
        frame_t.delete();
        for (int i = 0; i < 7; i++) send(8'($urandom));
        stop_send();
        chk("t4_full", fifo_full, 1'b1);
        chk("t4_drop", drop_cnt, 16'd2);
        wait_idle(400);
        chk("t4_frames", frame_t.size(), 5);

        // Reset during data bit 3
        send(8'h00);
        send(8'h11);
        send(8'h22);
        stop_send();
        repeat (17) @(negedge clock);
        chk("t5_pre", uart_tx, 1'b0);
        reset = 1'b0;
        #1;
        chk("t5_tx",    uart_tx,    1'b1);
        chk("t5_empty", fifo_empty, 1'b1);
        chk("t5_busy",  tx_busy,    1'b0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        saw_low = 0;
        repeat (60) begin
          @(negedge clock);
          if (uart_tx !== 1'b1) saw_low = 1;
        end
        chk("t5_idle_line", saw_low, 1'b0);
        chk("t5_empty_after", fifo_empty, 1'b1);

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
          @(negedge clock);
          io_uart_out_valid = (($urandom % 4) == 0) || (i % 200 < 12);
          io_uart_out_ch    = 8'($urandom);
        end
        stop_send();
        wait_idle(2000);
        chk("sb_drained", sb.size(), 0);
      end
      begin : flood
        repeat (3) @(negedge clock);
        reset2 = 1'b1;
        @(negedge clock);
        valid2 = 1'b1;
        repeat (70000) @(negedge clock);
        chk("sat_drop", drop2, 16'hFFFF);
        chk("sat_full", full2, 1'b1);
        repeat (50) @(negedge clock);
        chk("sat_hold", drop2, 16'hFFFF);
        valid2 = 1'b0;
      end
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
